// File: rtl/axi_tdd_ng_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : axi_tdd_ng_seq_pkg                                           |
// | Description : Shared state encoding and window slicing helpers for the     |
// |               TDD sequencer core.                                          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package axi_tdd_ng_seq_pkg;

    localparam int c_STATE_W = 3;

    typedef enum logic [c_STATE_W-1:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        WAITING = 3'd2,
        RUNNING = 3'd3,
        DONE    = 3'd4
    } state_t;

    // Bit offset of window `win` inside one channel's flattened window bus.
    function automatic int win_base(input int win, input int reg_width);
        return win * reg_width;
    endfunction

    // Bit offset of channel `ch` inside the channel-major flattened window bus.
    function automatic int ch_base(input int ch, input int win_count, input int reg_width);
        return ch * win_count * reg_width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_tdd_ng_seq_channel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : axi_tdd_ng_seq_channel                                       |
// | Description : One TDD output channel: window comparators, enable/polarity  |
// |               and the registered output pin.                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module axi_tdd_ng_seq_channel
    import axi_tdd_ng_seq_pkg::*;
#(
    parameter int WINDOW_COUNT     = 2,
    parameter int REGISTER_WIDTH   = 32,
    parameter bit DEFAULT_POLARITY = 1'b0
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   i_run,
    input  logic [REGISTER_WIDTH-1:0]              i_counter,
    input  logic                                   i_en,
    input  logic                                   i_pol,
    input  logic [WINDOW_COUNT*REGISTER_WIDTH-1:0] i_win_on,
    input  logic [WINDOW_COUNT*REGISTER_WIDTH-1:0] i_win_off,
    output logic                                   o_channel
);

    logic [WINDOW_COUNT-1:0] w_hit;
    logic                    w_channel_d;
    logic                    r_channel_q;

    generate
        for (genvar k = 0; k < WINDOW_COUNT; k++) begin : g_win
            logic [REGISTER_WIDTH-1:0] w_on;
            logic [REGISTER_WIDTH-1:0] w_off;

            assign w_on  = i_win_on[win_base(k, REGISTER_WIDTH) +: REGISTER_WIDTH];
            assign w_off = i_win_off[win_base(k, REGISTER_WIDTH) +: REGISTER_WIDTH];

            // on > off wraps through the end of the counter range; on == off is off.
            assign w_hit[k] = (w_on < w_off) ? ((i_counter >= w_on) && (i_counter < w_off)) :
                              (w_on > w_off) ? ((i_counter >= w_on) || (i_counter < w_off)) :
                                               1'b0;
        end
    endgenerate

    assign w_channel_d = ((i_run & (|w_hit)) & i_en) ^ i_pol;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_channel_q <= DEFAULT_POLARITY;
        end else begin
            r_channel_q <= w_channel_d;
        end
    end

    assign o_channel = r_channel_q;

endmodule
`default_nettype wire

// File: rtl/axi_tdd_ng_seq_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : axi_tdd_ng_seq_core                                          |
// | Description : TDD frame sequencer: FSM, frame/burst counters, shadowed     |
// |               configuration and CHANNEL_COUNT windowed output channels.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module axi_tdd_ng_seq_core
    import axi_tdd_ng_seq_pkg::*;
#(
    parameter int CHANNEL_COUNT     = 8,
    parameter int WINDOW_COUNT      = 2,
    parameter int REGISTER_WIDTH    = 32,
    parameter int BURST_COUNT_WIDTH = 32,
    parameter bit DEFAULT_POLARITY  = 1'b0
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              enable,
    input  logic                                              sync_in,
    input  logic                                              cfg_update,
    input  logic [REGISTER_WIDTH-1:0]                         cfg_startup_delay,
    input  logic [REGISTER_WIDTH-1:0]                         cfg_frame_length,
    input  logic [BURST_COUNT_WIDTH-1:0]                      cfg_burst_count,
    input  logic                                              cfg_rearm,
    input  logic [CHANNEL_COUNT-1:0]                          cfg_ch_en,
    input  logic [CHANNEL_COUNT-1:0]                          cfg_ch_pol,
    input  logic [CHANNEL_COUNT*WINDOW_COUNT*REGISTER_WIDTH-1:0] cfg_win_on,
    input  logic [CHANNEL_COUNT*WINDOW_COUNT*REGISTER_WIDTH-1:0] cfg_win_off,
    output logic                                              cfg_pending,
    output logic [2:0]                                        state,
    output logic [REGISTER_WIDTH-1:0]                         counter,
    output logic                                              active,
    output logic                                              end_of_frame,
    output logic                                              burst_done,
    output logic [CHANNEL_COUNT-1:0]                          tdd_channel
);

    localparam int c_WB    = CHANNEL_COUNT * WINDOW_COUNT * REGISTER_WIDTH;
    localparam int c_CFG_W = 2 * REGISTER_WIDTH + BURST_COUNT_WIDTH + 1 + 2 * CHANNEL_COUNT + 2 * c_WB;
    localparam logic [c_CFG_W-1:0] c_CFG_RST =
        {{(c_CFG_W - CHANNEL_COUNT){1'b0}}, {CHANNEL_COUNT{DEFAULT_POLARITY}}};
    localparam logic [REGISTER_WIDTH:0]      c_WAIT_ONE = 1;
    localparam logic [REGISTER_WIDTH-1:0]    c_CNT_ONE  = 1;
    localparam logic [BURST_COUNT_WIDTH-1:0] c_FRM_ONE  = 1;

    state_t                        r_state_q,   w_state_d;
    logic [REGISTER_WIDTH-1:0]     r_counter_q, w_counter_d;
    logic [BURST_COUNT_WIDTH-1:0]  r_frame_q,   w_frame_d;
    logic [c_CFG_W-1:0]            r_shadow_q,  w_shadow_d;
    logic [c_CFG_W-1:0]            r_active_q,  w_active_d;
    logic                          r_pending_q, w_pending_d;

    logic [c_CFG_W-1:0]            w_cfg_in;
    logic [REGISTER_WIDTH-1:0]     w_delay;
    logic [REGISTER_WIDTH-1:0]     w_flen;
    logic [BURST_COUNT_WIDTH-1:0]  w_burst;
    logic                          w_rearm;
    logic [CHANNEL_COUNT-1:0]      w_ch_en;
    logic [CHANNEL_COUNT-1:0]      w_ch_pol;
    logic [c_WB-1:0]               w_win_on;
    logic [c_WB-1:0]               w_win_off;
    logic                          w_running;
    logic                          w_eof;
    logic                          w_burst_done;
    logic                          w_quiet;
    logic                          w_apply;

    // Polarity sits in the low bits so the reset constant stays a simple pattern.
    assign w_cfg_in = {cfg_startup_delay, cfg_frame_length, cfg_burst_count, cfg_rearm,
                       cfg_ch_en, cfg_win_on, cfg_win_off, cfg_ch_pol};
    assign {w_delay, w_flen, w_burst, w_rearm, w_ch_en, w_win_on, w_win_off, w_ch_pol} = r_active_q;

    assign w_running    = (r_state_q == RUNNING);
    assign w_eof        = w_running && (r_counter_q == w_flen);
    assign w_burst_done = w_eof && (w_burst != '0) && (r_frame_q == (w_burst - c_FRM_ONE));
    assign w_quiet      = (r_state_q == IDLE) || (r_state_q == ARMED) || (r_state_q == DONE);
    assign w_apply      = r_pending_q && (w_quiet || w_eof);

    always_comb begin
        w_shadow_d  = r_shadow_q;
        w_active_d  = r_active_q;
        w_pending_d = r_pending_q;
        if (w_apply) begin
            w_active_d  = r_shadow_q;
            w_pending_d = 1'b0;
        end
        // A fresh capture racing an apply stays pending behind the older shadow.
        if (cfg_update) begin
            w_shadow_d = w_cfg_in;
            if (w_quiet && !r_pending_q) begin
                w_active_d = w_cfg_in;
            end else begin
                w_pending_d = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_d   = r_state_q;
        w_counter_d = r_counter_q;
        w_frame_d   = r_frame_q;
        if (!enable) begin
            w_state_d   = IDLE;
            w_counter_d = '0;
            w_frame_d   = '0;
        end else begin
            case (r_state_q)
                IDLE: begin
                    w_state_d   = ARMED;
                    w_counter_d = '0;
                end
                ARMED: begin
                    if (sync_in) begin
                        w_counter_d = '0;
                        w_frame_d   = '0;
                        w_state_d   = (w_delay == '0) ? RUNNING : WAITING;
                    end
                end
                WAITING: begin
                    if (({1'b0, r_counter_q} + c_WAIT_ONE) >= {1'b0, w_delay}) begin
                        w_state_d   = RUNNING;
                        w_counter_d = '0;
                    end else begin
                        w_counter_d = r_counter_q + c_CNT_ONE;
                    end
                end
                RUNNING: begin
                    if (w_eof) begin
                        w_counter_d = '0;
                        if (w_burst_done) begin
                            w_frame_d = '0;
                            w_state_d = w_rearm ? ARMED : DONE;
                        end else begin
                            w_frame_d = r_frame_q + c_FRM_ONE;
                        end
                    end else begin
                        w_counter_d = r_counter_q + c_CNT_ONE;
                    end
                end
                DONE:    w_state_d = DONE;
                default: w_state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q   <= IDLE;
            r_counter_q <= '0;
            r_frame_q   <= '0;
            r_shadow_q  <= c_CFG_RST;
            r_active_q  <= c_CFG_RST;
            r_pending_q <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_counter_q <= w_counter_d;
            r_frame_q   <= w_frame_d;
            r_shadow_q  <= w_shadow_d;
            r_active_q  <= w_active_d;
            r_pending_q <= w_pending_d;
        end
    end

    generate
        for (genvar c = 0; c < CHANNEL_COUNT; c++) begin : g_ch
            axi_tdd_ng_seq_channel #(
                .WINDOW_COUNT     (WINDOW_COUNT),
                .REGISTER_WIDTH   (REGISTER_WIDTH),
                .DEFAULT_POLARITY (DEFAULT_POLARITY)
            ) u_channel (
                .clk       (clk),
                .rst       (rst),
                .i_run     (w_running),
                .i_counter (r_counter_q),
                .i_en      (w_ch_en[c]),
                .i_pol     (w_ch_pol[c]),
                .i_win_on  (w_win_on[ch_base(c, WINDOW_COUNT, REGISTER_WIDTH) +: WINDOW_COUNT*REGISTER_WIDTH]),
                .i_win_off (w_win_off[ch_base(c, WINDOW_COUNT, REGISTER_WIDTH) +: WINDOW_COUNT*REGISTER_WIDTH]),
                .o_channel (tdd_channel[c])
            );
        end
    endgenerate

    assign cfg_pending  = r_pending_q;
    assign state        = r_state_q;
    assign counter      = r_counter_q;
    assign active       = w_running;
    assign end_of_frame = w_eof;
    assign burst_done   = w_burst_done;

endmodule
`default_nettype wire

// File: tb/tb_axi_tdd_ng_seq_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_axi_tdd_ng_seq_core                                       |
// | Description : Scoreboard bench for axi_tdd_ng_seq_core; expected outputs   |
// |               come from a per-scenario timeline model.                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_axi_tdd_ng_seq_core;

    localparam int c_CH  = 8;
    localparam int c_WIN = 2;
    localparam int c_RW  = 32;
    localparam int c_BW  = 32;

    logic clk = 1'b0, rst = 1'b1, enable = 1'b0, sync_in = 1'b0, cfg_update = 1'b0;
    logic [c_RW-1:0] cfg_startup_delay = '0, cfg_frame_length = '0;
    logic [c_BW-1:0] cfg_burst_count = '0;
    logic            cfg_rearm = 1'b0;
    logic [c_CH-1:0] cfg_ch_en = '0, cfg_ch_pol = '0;
    logic [c_CH*c_WIN*c_RW-1:0] cfg_win_on = '0, cfg_win_off = '0;
    logic            cfg_pending, active, end_of_frame, burst_done;
    logic [2:0]      state;
    logic [c_RW-1:0] counter;
    logic [c_CH-1:0] tdd_channel;

    axi_tdd_ng_seq_core #(
        .CHANNEL_COUNT(c_CH), .WINDOW_COUNT(c_WIN), .REGISTER_WIDTH(c_RW),
        .BURST_COUNT_WIDTH(c_BW), .DEFAULT_POLARITY(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .sync_in(sync_in), .cfg_update(cfg_update),
        .cfg_startup_delay(cfg_startup_delay), .cfg_frame_length(cfg_frame_length),
        .cfg_burst_count(cfg_burst_count), .cfg_rearm(cfg_rearm), .cfg_ch_en(cfg_ch_en),
        .cfg_ch_pol(cfg_ch_pol), .cfg_win_on(cfg_win_on), .cfg_win_off(cfg_win_off),
        .cfg_pending(cfg_pending), .state(state), .counter(counter), .active(active),
        .end_of_frame(end_of_frame), .burst_done(burst_done), .tdd_channel(tdd_channel)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int              cyc;
        int              st;
        int              cnt;
        logic            act, eof, bd, pend;
        logic [c_CH-1:0] ch;
    } exp_t;

    exp_t exp_q[$];
    exp_t m_e;
    int   n_chk = 0;
    int   n_fail = 0;

    // Scenario description: old config (index 0) and the mid-frame update (index 1).
    int       sc_d, sc_f, sc_b, sc_m, sc_a, sc_y;
    bit       sc_rearm, sc_upd;
    logic [c_CH-1:0] en_a [2];
    logic [c_CH-1:0] pol_a[2];
    int       on_a [2][c_CH][c_WIN];
    int       off_a[2][c_CH][c_WIN];
    int       t_s, t_r, t_z;

    task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        n_chk++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act_v, exp_v);
        end
    endtask

    always @(negedge clk) begin
        while (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
            m_e = exp_q.pop_front();
            chk("stale_entry", 32'(cyc), 32'(m_e.cyc));
        end
        if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
            m_e = exp_q.pop_front();
            chk("state",        32'(state),        32'(m_e.st));
            chk("counter",      counter,           32'(m_e.cnt));
            chk("active",       32'(active),       32'(m_e.act));
            chk("end_of_frame", 32'(end_of_frame), 32'(m_e.eof));
            chk("burst_done",   32'(burst_done),   32'(m_e.bd));
            chk("cfg_pending",  32'(cfg_pending),  32'(m_e.pend));
            chk("tdd_channel",  32'(tdd_channel),  32'(m_e.ch));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cfg(input int sel);
        cfg_startup_delay = c_RW'(sc_d);
        cfg_frame_length  = c_RW'(sc_f);
        cfg_burst_count   = c_BW'(sc_b);
        cfg_rearm         = sc_rearm;
        cfg_ch_en         = en_a[sel];
        cfg_ch_pol        = pol_a[sel];
        for (int c = 0; c < c_CH; c++) begin
            for (int k = 0; k < c_WIN; k++) begin
                cfg_win_on[(c*c_WIN+k)*c_RW +: c_RW]  = c_RW'(on_a[sel][c][k]);
                cfg_win_off[(c*c_WIN+k)*c_RW +: c_RW] = c_RW'(off_a[sel][c][k]);
            end
        end
    endtask

    task automatic clear_cfg();
        sc_m = 1; sc_a = 0; sc_y = 0; sc_rearm = 0; sc_upd = 0;
        for (int s = 0; s < 2; s++) begin
            en_a[s] = '0; pol_a[s] = '0;
            for (int c = 0; c < c_CH; c++)
                for (int k = 0; k < c_WIN; k++) begin
                    on_a[s][c][k] = 0; off_a[s][c][k] = 0;
                end
        end
    endtask

    task automatic copy_cfg();
        en_a[1] = en_a[0]; pol_a[1] = pol_a[0];
        for (int c = 0; c < c_CH; c++)
            for (int k = 0; k < c_WIN; k++) begin
                on_a[1][c][k] = on_a[0][c][k]; off_a[1][c][k] = off_a[0][c][k];
            end
    endtask

    // Where the sequencer should be at cycle t, derived from the sync time.
    function automatic void model_at(input int t, output int st, output int cnt, output int fr);
        int runlen;
        runlen = sc_b * (sc_f + 1);
        fr = 0; cnt = 0;
        if (t >= t_z)                st = 0;
        else if (t < t_s)            st = 1;
        else if (t < t_r) begin      st = 2; cnt = t - t_s; end
        else if (t < t_r + runlen) begin
            st = 3; cnt = (t - t_r) % (sc_f + 1); fr = (t - t_r) / (sc_f + 1);
        end else                     st = sc_rearm ? 1 : 4;
    endfunction

    function automatic bit win_hit(input int sel, input int c, input int cnt);
        for (int k = 0; k < c_WIN; k++) begin
            int on_v, off_v;
            on_v = on_a[sel][c][k]; off_v = off_a[sel][c][k];
            if (on_v < off_v && cnt >= on_v && cnt < off_v) return 1'b1;
            if (on_v > off_v && (cnt >= on_v || cnt < off_v)) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic run_scenario();
        int   st, cnt, fr, pst, pcnt, pfr, sel, last_pend;
        exp_t e;
        enable = 0; sync_in = 0; drive_cfg(0); cfg_update = 1; step(); cfg_update = 0; step();
        enable = 1; step(); step();
        sync_in = 1;
        t_s = cyc + 1;
        t_r = t_s + sc_d;
        t_z = (sc_a != 0) ? t_r + sc_a : t_r + sc_b * (sc_f + 1) + 3;
        last_pend = (t_r + sc_f < t_z) ? t_r + sc_f : t_z;
        for (int t = t_s; t <= t_z + 2; t++) begin
            model_at(t, st, cnt, fr);
            model_at(t - 1, pst, pcnt, pfr);
            sel = (sc_upd && (t - 1 >= last_pend + 1)) ? 1 : 0;
            e.cyc  = t;
            e.st   = st;
            e.cnt  = cnt;
            e.act  = (st == 3);
            e.eof  = (st == 3) && (cnt == sc_f);
            e.bd   = e.eof && (fr == sc_b - 1);
            e.pend = sc_upd && (t >= t_r + sc_m) && (t <= last_pend);
            for (int c = 0; c < c_CH; c++)
                e.ch[c] = pol_a[sel][c] ^ (en_a[sel][c] & (pst == 3) & win_hit(sel, c, pcnt));
            exp_q.push_back(e);
        end
        step();
        for (int n = t_s; n <= t_z + 1; n++) begin
            sync_in    = (sc_y != 0) && (n + 1 == t_r + sc_y);
            cfg_update = sc_upd && (n + 1 == t_r + sc_m);
            if (cfg_update) drive_cfg(1);
            enable = (n + 1 < t_z);
            step();
        end
        sync_in = 0; cfg_update = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int t = 1; t <= 2; t++) begin
            m_e.cyc = t; m_e.st = 0; m_e.cnt = 0; m_e.act = 0; m_e.eof = 0;
            m_e.bd = 0; m_e.pend = 0; m_e.ch = '1;
            exp_q.push_back(m_e);
        end
        step(); step();
        rst = 0;
        step();

        // Basic frame: delay 3, length 10, two frames, ch0 window [2,5).
        clear_cfg(); sc_d = 3; sc_f = 9; sc_b = 2; en_a[0] = 8'h01;
        on_a[0][0][0] = 2; off_a[0][0][0] = 5;
        run_scenario();
        // Wrap-around window 8..1.
        clear_cfg(); sc_d = 1; sc_f = 9; sc_b = 2; en_a[0] = 8'h01; pol_a[0] = 8'h40;
        on_a[0][0][0] = 8; off_a[0][0][0] = 2;
        run_scenario();
        // Two windows, then second window degenerate.
        clear_cfg(); sc_d = 2; sc_f = 9; sc_b = 1; en_a[0] = 8'h01;
        on_a[0][0][0] = 1; off_a[0][0][0] = 3; on_a[0][0][1] = 6; off_a[0][0][1] = 7;
        run_scenario();
        off_a[0][0][1] = 6;
        run_scenario();
        // Mid-frame shadow update moving the window start to 4.
        clear_cfg(); sc_d = 2; sc_f = 9; sc_b = 3; en_a[0] = 8'h03;
        on_a[0][0][0] = 2; off_a[0][0][0] = 5; on_a[0][1][0] = 7; off_a[0][1][0] = 3;
        copy_cfg(); on_a[1][0][0] = 4; sc_upd = 1; sc_m = 3;
        run_scenario();
        // Rearm after a single frame, with a sync during RUNNING that must be ignored.
        clear_cfg(); sc_d = 0; sc_f = 5; sc_b = 1; sc_rearm = 1; sc_y = 2; en_a[0] = 8'h01;
        on_a[0][0][0] = 1; off_a[0][0][0] = 4;
        run_scenario();
        // Abort mid-frame with inverted channels.
        clear_cfg(); sc_d = 1; sc_f = 9; sc_b = 2; sc_a = 6; en_a[0] = 8'hFF; pol_a[0] = 8'hA5;
        for (int c = 0; c < c_CH; c++) begin on_a[0][c][0] = c; off_a[0][c][0] = c + 3; end
        run_scenario();

        for (int it = 0; it < 24; it++) begin
            clear_cfg();
            sc_d = $urandom_range(0, 4); sc_f = $urandom_range(1, 9); sc_b = $urandom_range(1, 3);
            sc_rearm = 1'($urandom);
            for (int s = 0; s < 2; s++) begin
                en_a[s] = 8'($urandom); pol_a[s] = 8'($urandom);
                for (int c = 0; c < c_CH; c++)
                    for (int k = 0; k < c_WIN; k++) begin
                        on_a[s][c][k]  = $urandom_range(0, sc_f + 2);
                        off_a[s][c][k] = $urandom_range(0, sc_f + 2);
                    end
            end
            sc_upd = (sc_b >= 2) && ($urandom_range(0, 1) == 1);
            sc_m   = $urandom_range(1, sc_f);
            sc_a   = ($urandom_range(0, 2) == 0) ? $urandom_range(1, sc_b * (sc_f + 1) - 1) : 0;
            if (sc_a != 0 && sc_a <= sc_m) sc_upd = 0;
            sc_y   = ($urandom_range(0, 1) == 1) ? $urandom_range(1, sc_b * (sc_f + 1) - 1) : 0;
            if (sc_a != 0 && sc_y > sc_a) sc_y = 0;
            run_scenario();
        end

        for (int w = 0; w < 20 && exp_q.size() != 0; w++) step();
        if (exp_q.size() != 0) begin
            n_chk++; n_fail++;
            $display("FAIL drain actual=%0d entries left required=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_tdd_ng_seq_core.md
Name: axi_tdd_ng_seq_core

Overview:
- Next-generation TDD timing core: frame counter FSM plus CHANNEL_COUNT outputs, each driven by WINDOW_COUNT independent on/off windows per frame.
- Adds shadowed configuration applied only at frame boundaries, wrap-around windows and optional re-arm after a burst.
- Sits between the TDD register map (config, control) and the TDD channel pins; all inputs are in the TDD clock domain (CDC handled upstream).

Parameters:
- CHANNEL_COUNT, 8, number of output channels (1..32)
- WINDOW_COUNT, 2, on/off windows per channel (1..4)
- REGISTER_WIDTH, 32, width of counter, delay, frame length and window registers
- BURST_COUNT_WIDTH, 32, width of burst count
- DEFAULT_POLARITY, 0, reset value of every polarity bit, replicated per channel

Ports:
- clk  in  1  TDD clock
- rst  in  1  synchronous active-high reset
- enable  in  1  core enable; low forces IDLE
- sync_in  in  1  single-cycle sync/trigger pulse
- cfg_update  in  1  pulse: capture cfg_* into shadow registers
- cfg_startup_delay  in  REGISTER_WIDTH  cycles from sync to first frame
- cfg_frame_length  in  REGISTER_WIDTH  frame length minus 1
- cfg_burst_count  in  BURST_COUNT_WIDTH  frames per burst; 0 = infinite
- cfg_rearm  in  1  after burst completes, return to ARMED instead of DONE
- cfg_ch_en  in  CHANNEL_COUNT  per-channel enable
- cfg_ch_pol  in  CHANNEL_COUNT  per-channel polarity (1 = inverted)
- cfg_win_on  in  CHANNEL_COUNT*WINDOW_COUNT*REGISTER_WIDTH  window start, flattened, channel-major
- cfg_win_off  in  CHANNEL_COUNT*WINDOW_COUNT*REGISTER_WIDTH  window end (exclusive)
- cfg_pending  out  1  shadow captured, not yet applied
- state  out  3  FSM state
- counter  out  REGISTER_WIDTH  current counter
- active  out  1  state == RUNNING
- end_of_frame  out  1  pulse on last frame cycle
- burst_done  out  1  pulse when final frame of a burst ends
- tdd_channel  out  CHANNEL_COUNT  channel outputs

Behaviour:
- Reset: state IDLE; counter 0; active, end_of_frame, burst_done, cfg_pending 0; shadow and active config 0 except polarity = DEFAULT_POLARITY; tdd_channel = DEFAULT_POLARITY.
- States: IDLE, ARMED, WAITING, RUNNING, DONE.
- IDLE -> ARMED when enable=1. enable=0 in any state -> IDLE next cycle, counter 0, outputs return to polarity level.
- ARMED -> WAITING on sync_in. If startup_delay=0, go directly to RUNNING with counter 0.
- WAITING: counter counts 0..startup_delay-1, then RUNNING with counter 0.
- RUNNING: counter counts 0..frame_length; end_of_frame=1 when counter==frame_length; counter then wraps to 0.
- Frame counting is internal, BURST_COUNT_WIDTH wide. On the end_of_frame of frame number burst_count (nonzero): burst_done=1; next state is ARMED if rearm=1, else DONE.
- DONE holds until enable is deasserted.
- sync_in outside ARMED is ignored.
- cfg_update: copy all cfg_* into shadow and set cfg_pending. Shadow becomes active:
  - on the same cycle in IDLE, ARMED or DONE;
  - in WAITING or RUNNING, at the end_of_frame cycle, so the next frame uses the new values.
  - cfg_pending clears when the shadow is applied.
  - cfg_update coinciding with an apply: the new values are captured and remain pending; the earlier shadow is applied.
- Window k of channel c is active when:
  - on<off: on<=counter<off;
  - on>off: counter>=on or counter<off (wrap-around);
  - on==off: disabled.
- raw = OR of active windows, computed only in RUNNING, else 0.
- tdd_channel[c] registered: (raw & ch_en[c]) ^ pol[c]. Latency is 1 cycle after counter.
- Disabled channel: output equals polarity.

Decomposition:
- Package axi_tdd_ng_seq_pkg: state_t enum (IDLE=0, ARMED=1, WAITING=2, RUNNING=3, DONE=4) and window index helper constants.
- Sub-module axi_tdd_ng_seq_channel: one channel. Holds WINDOW_COUNT comparators, enable/polarity and the output register; instantiated CHANNEL_COUNT times by generate.
- The top holds the FSM, counter, burst counter and shadow registers.

Test Plan:
- Reset: rst=1 for 2 cycles with DEFAULT_POLARITY=1 -> tdd_channel all ones, state IDLE, counter 0.
- Basic frame: delay=3, frame_length=9, burst=2, ch0 window on=2/off=5. Enable, then sync:
  - WAITING 3 cycles, then RUNNING;
  - ch0 high for counter 2,3,4 (output lags by 1 cycle);
  - end_of_frame at counter 9;
  - burst_done after second frame, then DONE.
- Wrap window: frame_length=9, on=8/off=2 -> ch0 high for counter 8,9,0,1 in every frame.
- Two windows plus on==off: win0 on=1/off=3, win1 on=6/off=7 -> high at 1,2,6. Set win1 on=off=6 -> high only at 1,2.
- Shadow update: cfg_update mid-frame changing on=4 -> cfg_pending=1; old window holds until end_of_frame; new window from next frame; cfg_pending clears.
- Rearm and abort: rearm=1, burst=1 -> ARMED after frame and waits for a new sync; a sync in RUNNING is ignored; enable=0 mid-frame -> IDLE next cycle, outputs at polarity.
